// File: rtl/ip_rx_pkg.sv
// Shared definitions for the IP receive deframer: FSM states, IPv4 header field
// offsets within the packed 160-bit header, and FIFO framing constants.
package ip_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_PAYLOAD,
        ST_PAD,
        ST_DRAIN,
        ST_DROP
    } rx_state_t;

    localparam int HDR_WIDTH       = 160;
    localparam int HDR_VERSION_LSB = 0;
    localparam int HDR_VERSION_W   = 4;
    localparam int HDR_IHL_LSB     = 4;
    localparam int HDR_IHL_W       = 4;
    localparam int HDR_DSCP_LSB    = 8;
    localparam int HDR_DSCP_W      = 6;
    localparam int HDR_ECN_LSB     = 14;
    localparam int HDR_ECN_W       = 2;
    localparam int HDR_LENGTH_LSB  = 16;
    localparam int HDR_LENGTH_W    = 16;
    localparam int HDR_IDENT_LSB   = 32;
    localparam int HDR_IDENT_W     = 16;
    localparam int HDR_FLAGS_LSB   = 48;
    localparam int HDR_FLAGS_W     = 3;
    localparam int HDR_FRAG_LSB    = 51;
    localparam int HDR_FRAG_W      = 13;
    localparam int HDR_TTL_LSB     = 64;
    localparam int HDR_TTL_W       = 8;
    localparam int HDR_PROTO_LSB   = 72;
    localparam int HDR_PROTO_W     = 8;
    localparam int HDR_CSUM_LSB    = 80;
    localparam int HDR_CSUM_W      = 16;
    localparam int HDR_SRC_LSB     = 96;
    localparam int HDR_DST_LSB     = 128;
    localparam int HDR_IP_W        = 32;

    localparam logic [7:0] IP_PROTO_UDP = 8'd17;
    localparam int         PREFIX_LEN   = 10;

    // IHL is expressed in 32-bit words; the framer works in bytes.
    function automatic logic [15:0] ihl_bytes(input logic [3:0] ihl);
        return {10'd0, ihl, 2'b00};
    endfunction

endpackage

// File: rtl/ip_rx_deframer_sat_counter.sv
// Saturating event counter: increments on inc, holds at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] value
);

    logic [CNT_WIDTH-1:0] value_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= '0;
        end else if (inc && (value_reg != {CNT_WIDTH{1'b1}})) begin
            value_reg <= value_reg + CNT_WIDTH'(1);
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/ip_rx_deframer.sv
// Serialises accepted UDP datagrams into the RX byte FIFO as a 10-byte prefix
// (src ip, dest ip, payload length) followed by a length-corrected payload.
module ip_rx_deframer
    import ip_rx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1472,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 rx_hdr_valid,
    output logic                 rx_hdr_ready,
    input  logic [HDR_WIDTH-1:0] rx_hdr,
    input  logic                 rx_payload_TVALID,
    output logic                 rx_payload_TREADY,
    input  logic [7:0]           rx_payload_TDATA,
    input  logic                 rx_payload_TLAST,
    output logic [7:0]           dout_V_din,
    input  logic                 dout_V_full_n,
    output logic                 dout_V_write,
    output logic [CNT_WIDTH-1:0] stat_ok,
    output logic [CNT_WIDTH-1:0] stat_drop,
    output logic [CNT_WIDTH-1:0] stat_len_err
);

    localparam logic [15:0] MAX_PLEN    = 16'(MAX_PAYLOAD);
    localparam logic [3:0]  LAST_PREFIX = 4'(PREFIX_LEN - 1);

    rx_state_t   state_reg;
    logic        ready_en_reg;
    logic [31:0] src_ip_reg;
    logic [31:0] dest_ip_reg;
    logic [15:0] plen_reg;
    logic [15:0] count_reg;
    logic [3:0]  idx_reg;

    logic [3:0]  hdr_version;
    logic [3:0]  hdr_ihl;
    logic [15:0] hdr_length;
    logic [7:0]  hdr_proto;
    logic [31:0] hdr_src;
    logic [31:0] hdr_dst;
    logic [15:0] hdr_ihl_bytes;
    logic [15:0] hdr_plen;
    logic        hdr_bad;
    logic        hdr_accept;
    logic        unused_hdr_bits;

    assign hdr_version   = rx_hdr[HDR_VERSION_LSB +: HDR_VERSION_W];
    assign hdr_ihl       = rx_hdr[HDR_IHL_LSB +: HDR_IHL_W];
    assign hdr_length    = rx_hdr[HDR_LENGTH_LSB +: HDR_LENGTH_W];
    assign hdr_proto     = rx_hdr[HDR_PROTO_LSB +: HDR_PROTO_W];
    assign hdr_src       = rx_hdr[HDR_SRC_LSB +: HDR_IP_W];
    assign hdr_dst       = rx_hdr[HDR_DST_LSB +: HDR_IP_W];
    assign hdr_ihl_bytes = ihl_bytes(hdr_ihl);
    assign hdr_plen      = hdr_length - hdr_ihl_bytes;

    // Fields the deframer does not act on (tos, ident/flags/frag, ttl, checksum).
    assign unused_hdr_bits = ^{rx_hdr[HDR_DSCP_LSB +: HDR_DSCP_W + HDR_ECN_W],
                               rx_hdr[HDR_IDENT_LSB +: HDR_IDENT_W + HDR_FLAGS_W + HDR_FRAG_W + HDR_TTL_W],
                               rx_hdr[HDR_CSUM_LSB +: HDR_CSUM_W]};

    // The length floor check runs before plen is trusted, so a wrapped plen never matters.
    assign hdr_bad = (hdr_proto != IP_PROTO_UDP) ||
                     (hdr_version != 4'd4) ||
                     (hdr_ihl < 4'd5) ||
                     (hdr_length < (hdr_ihl_bytes + 16'd8)) ||
                     (hdr_plen > MAX_PLEN);

    assign rx_hdr_ready = ready_en_reg && (state_reg == ST_IDLE);
    assign hdr_accept   = rx_hdr_valid && rx_hdr_ready;

    logic [7:0] prefix_bytes [PREFIX_LEN];

    generate
        genvar gi;
        for (gi = 0; gi < 4; gi++) begin : g_ip_bytes
            assign prefix_bytes[gi]     = src_ip_reg[31 - 8*gi -: 8];
            assign prefix_bytes[gi + 4] = dest_ip_reg[31 - 8*gi -: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_len_bytes
            assign prefix_bytes[gi + 8] = plen_reg[15 - 8*gi -: 8];
        end
    endgenerate

    logic [15:0] count_inc;
    logic        count_done;
    logic        pay_xfer;
    logic        pad_wr;
    logic        tail_xfer;
    logic        ok_inc;
    logic        len_err_inc;
    logic        drop_inc;

    assign count_inc  = count_reg + 16'd1;
    assign count_done = (count_inc == plen_reg);
    assign pay_xfer   = (state_reg == ST_PAYLOAD) && rx_payload_TVALID && dout_V_full_n;
    assign pad_wr     = (state_reg == ST_PAD) && dout_V_full_n;
    assign tail_xfer  = ((state_reg == ST_DRAIN) || (state_reg == ST_DROP)) &&
                        rx_payload_TVALID && rx_payload_TLAST;

    assign ok_inc      = (pay_xfer || pad_wr) && count_done;
    assign len_err_inc = (pay_xfer && count_done && !rx_payload_TLAST) || (pad_wr && count_done);
    assign drop_inc    = hdr_accept && hdr_bad;

    always_comb begin
        rx_payload_TREADY = 1'b0;
        dout_V_write      = 1'b0;
        dout_V_din        = 8'h00;
        unique case (state_reg)
            ST_PREFIX: begin
                dout_V_write = dout_V_full_n;
                dout_V_din   = prefix_bytes[idx_reg];
            end
            ST_PAYLOAD: begin
                rx_payload_TREADY = dout_V_full_n;
                dout_V_write      = rx_payload_TVALID && dout_V_full_n;
                dout_V_din        = rx_payload_TDATA;
            end
            ST_PAD: begin
                dout_V_write = dout_V_full_n;
            end
            ST_DRAIN, ST_DROP: begin
                rx_payload_TREADY = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg    <= ST_IDLE;
            ready_en_reg <= 1'b0;
            src_ip_reg   <= '0;
            dest_ip_reg  <= '0;
            plen_reg     <= '0;
            count_reg    <= '0;
            idx_reg      <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            unique case (state_reg)
                ST_IDLE: begin
                    if (hdr_accept) begin
                        src_ip_reg  <= hdr_src;
                        dest_ip_reg <= hdr_dst;
                        plen_reg    <= hdr_plen;
                        count_reg   <= '0;
                        idx_reg     <= '0;
                        state_reg   <= hdr_bad ? ST_DROP : ST_PREFIX;
                    end
                end
                ST_PREFIX: begin
                    if (dout_V_full_n) begin
                        idx_reg <= idx_reg + 4'd1;
                        if (idx_reg == LAST_PREFIX) begin
                            count_reg <= '0;
                            state_reg <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_xfer) begin
                        count_reg <= count_inc;
                        if (count_done) begin
                            state_reg <= rx_payload_TLAST ? ST_IDLE : ST_DRAIN;
                        end else if (rx_payload_TLAST) begin
                            state_reg <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    if (pad_wr) begin
                        count_reg <= count_inc;
                        if (count_done) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN, ST_DROP: begin
                    if (tail_xfer) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stat_ok (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .inc   (ok_inc),
        .value (stat_ok)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stat_drop (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .inc   (drop_inc),
        .value (stat_drop)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stat_len_err (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .inc   (len_err_inc),
        .value (stat_len_err)
    );

endmodule

// File: tb/tb_ip_rx_deframer.sv
// Directed bench for ip_rx_deframer: forwarding, drop, pad, drain, backpressure, reset.
module tb_ip_rx_deframer;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n;
    logic         rx_hdr_valid;
    logic         rx_hdr_ready;
    logic [159:0] rx_hdr;
    logic         rx_payload_TVALID;
    logic         rx_payload_TREADY;
    logic [7:0]   rx_payload_TDATA;
    logic         rx_payload_TLAST;
    logic [7:0]   dout_V_din;
    logic         dout_V_full_n;
    logic         dout_V_write;
    logic [15:0]  stat_ok;
    logic [15:0]  stat_drop;
    logic [15:0]  stat_len_err;

    ip_rx_deframer #(.MAX_PAYLOAD(1472), .CNT_WIDTH(16)) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .rx_hdr_valid      (rx_hdr_valid),
        .rx_hdr_ready      (rx_hdr_ready),
        .rx_hdr            (rx_hdr),
        .rx_payload_TVALID (rx_payload_TVALID),
        .rx_payload_TREADY (rx_payload_TREADY),
        .rx_payload_TDATA  (rx_payload_TDATA),
        .rx_payload_TLAST  (rx_payload_TLAST),
        .dout_V_din        (dout_V_din),
        .dout_V_full_n     (dout_V_full_n),
        .dout_V_write      (dout_V_write),
        .stat_ok           (stat_ok),
        .stat_drop         (stat_drop),
        .stat_len_err      (stat_len_err)
    );

    always #5 ap_clk = ~ap_clk;

    localparam logic [31:0] SRC_IP = 32'hC0A8010A;
    localparam logic [31:0] DST_IP = 32'hC0A80164;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;
    bit bp_mon = 1'b0;
    logic [7:0] cap_q [$];
    int         cap_cyc [$];
    logic [7:0] exp_q [$];

    // FIFO-side monitor: records every write and the edge index it happened on.
    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (dout_V_write) begin
            cap_q.push_back(dout_V_din);
            cap_cyc.push_back(cyc);
        end
        if (bp_mon && !dout_V_full_n && (dout_V_write || rx_payload_TREADY))
            viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] mk_hdr(input logic [3:0] ihl, input logic [15:0] len,
                                            input logic [7:0] proto);
        logic [159:0] h;
        h = '0;
        h[3:0]     = 4'd4;
        h[7:4]     = ihl;
        h[31:16]   = len;
        h[71:64]   = 8'd64;
        h[79:72]   = proto;
        h[127:96]  = SRC_IP;
        h[159:128] = DST_IP;
        return h;
    endfunction

    task automatic send_hdr(input logic [159:0] h, output int acc);
        acc = -1;
        rx_hdr       = h;
        rx_hdr_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (rx_hdr_ready) begin
                acc = cyc;
                @(negedge ap_clk);
                break;
            end
            @(negedge ap_clk);
        end
        rx_hdr_valid = 1'b0;
        if (acc < 0) check("hdr_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_payload(input int n, input logic [7:0] start, input bit last,
                                output int not_ready);
        bit took;
        not_ready = 0;
        for (int i = 0; i < n; i++) begin
            rx_payload_TVALID = 1'b1;
            rx_payload_TDATA  = start + 8'(i);
            rx_payload_TLAST  = last && (i == n - 1);
            took = 1'b0;
            for (int t = 0; t < 200 && !took; t++) begin
                #1;
                took = rx_payload_TREADY;
                @(negedge ap_clk);
                if (!took) not_ready++;
            end
            if (!took) begin
                check("payload_timeout", 32'd0, 32'd1);
                break;
            end
        end
        rx_payload_TVALID = 1'b0;
        rx_payload_TLAST  = 1'b0;
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            #1;
            seen = rx_hdr_ready;
            if (!seen) @(negedge ap_clk);
        end
        if (!seen) check("idle_timeout", 32'd0, 32'd1);
        @(negedge ap_clk);
    endtask

    task automatic push_prefix(input logic [15:0] plen);
        exp_q.push_back(8'hC0); exp_q.push_back(8'hA8); exp_q.push_back(8'h01); exp_q.push_back(8'h0A);
        exp_q.push_back(8'hC0); exp_q.push_back(8'hA8); exp_q.push_back(8'h01); exp_q.push_back(8'h64);
        exp_q.push_back(plen[15:8]);
        exp_q.push_back(plen[7:0]);
    endtask

    task automatic push_bytes(input int n, input logic [7:0] start);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 8'(i));
    endtask

    task automatic check_frame(input string tag);
        int n;
        check($sformatf("%s_len", tag), 32'(cap_q.size()), 32'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
        $display("frame %s: %0d bytes captured, %0d expected", tag, cap_q.size(), exp_q.size());
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int nr;

        ap_rst_n          = 1'b1;
        rx_hdr_valid      = 1'b0;
        rx_hdr            = '0;
        rx_payload_TVALID = 1'b0;
        rx_payload_TDATA  = 8'h00;
        rx_payload_TLAST  = 1'b0;
        dout_V_full_n     = 1'b1;
        #1 ap_rst_n = 1'b0;
        #1;
        check("rst_hdr_ready", 32'(rx_hdr_ready), 32'd0);
        check("rst_tready", 32'(rx_payload_TREADY), 32'd0);
        check("rst_write", 32'(dout_V_write), 32'd0);
        check("rst_din", 32'(dout_V_din), 32'd0);
        check("rst_stat_ok", 32'(stat_ok), 32'd0);
        check("rst_stat_drop", 32'(stat_drop), 32'd0);
        check("rst_stat_len_err", 32'(stat_len_err), 32'd0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        #1 check("post_rst_hdr_ready", 32'(rx_hdr_ready), 32'd1);

        // Basic UDP datagram, plen 16.
        send_hdr(mk_hdr(4'd5, 16'd36, 8'd17), acc);
        send_payload(16, 8'h00, 1'b1, nr);
        wait_idle();
        check("udp_len", 32'(cap_q.size()), 32'd26);
        if (cap_q.size() == 26) begin
            check("udp_first_cycle", 32'(cap_cyc[0]), 32'(acc + 1));
            check("udp_last_cycle", 32'(cap_cyc[25]), 32'(acc + 26));
        end
        push_prefix(16'd16);
        push_bytes(16, 8'h00);
        check_frame("udp");
        check("udp_stat_ok", 32'(stat_ok), 32'd1);

        // TCP datagram is dropped, then a UDP datagram passes intact.
        send_hdr(mk_hdr(4'd5, 16'd40, 8'd6), acc);
        send_payload(20, 8'h40, 1'b1, nr);
        check("drop_tready_stalls", 32'(nr), 32'd0);
        wait_idle();
        check_frame("drop");
        check("drop_stat_drop", 32'(stat_drop), 32'd1);
        check("drop_stat_ok", 32'(stat_ok), 32'd1);
        send_hdr(mk_hdr(4'd5, 16'd36, 8'd17), acc);
        send_payload(16, 8'h80, 1'b1, nr);
        wait_idle();
        push_prefix(16'd16);
        push_bytes(16, 8'h80);
        check_frame("after_drop");
        check("after_drop_stat_ok", 32'(stat_ok), 32'd2);

        // Short payload: 10 of 16 bytes, padded with zeros.
        send_hdr(mk_hdr(4'd5, 16'd36, 8'd17), acc);
        send_payload(10, 8'hA0, 1'b1, nr);
        wait_idle();
        push_prefix(16'd16);
        push_bytes(10, 8'hA0);
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h00);
        check_frame("pad");
        check("pad_stat_ok", 32'(stat_ok), 32'd3);
        check("pad_stat_len_err", 32'(stat_len_err), 32'd1);

        // Long payload: plen 8, 12 bytes supplied, tail drained.
        send_hdr(mk_hdr(4'd5, 16'd28, 8'd17), acc);
        send_payload(12, 8'hB0, 1'b1, nr);
        wait_idle();
        push_prefix(16'd8);
        push_bytes(8, 8'hB0);
        check_frame("drain");
        check("drain_stat_ok", 32'(stat_ok), 32'd4);
        check("drain_stat_len_err", 32'(stat_len_err), 32'd2);

        // FIFO backpressure mid-prefix (3 cycles) and mid-payload (5 cycles).
        bp_mon = 1'b1;
        fork
            begin
                send_hdr(mk_hdr(4'd5, 16'd36, 8'd17), acc);
                send_payload(16, 8'hC0, 1'b1, nr);
            end
            begin
                repeat (3) @(negedge ap_clk);
                dout_V_full_n = 1'b0;
                repeat (3) @(negedge ap_clk);
                dout_V_full_n = 1'b1;
                repeat (10) @(negedge ap_clk);
                dout_V_full_n = 1'b0;
                repeat (5) @(negedge ap_clk);
                dout_V_full_n = 1'b1;
            end
        join
        wait_idle();
        bp_mon = 1'b0;
        check("bp_violations", 32'(viol), 32'd0);
        push_prefix(16'd16);
        push_bytes(16, 8'hC0);
        check_frame("bp");
        check("bp_stat_ok", 32'(stat_ok), 32'd5);

        // Asynchronous reset in the middle of a payload.
        send_hdr(mk_hdr(4'd5, 16'd36, 8'd17), acc);
        send_payload(5, 8'h10, 1'b0, nr);
        rx_payload_TVALID = 1'b1;
        rx_payload_TDATA  = 8'h55;
        #2;
        check("pre_rst_din", 32'(dout_V_din), 32'h55);
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_write", 32'(dout_V_write), 32'd0);
        check("mid_rst_din", 32'(dout_V_din), 32'd0);
        check("mid_rst_tready", 32'(rx_payload_TREADY), 32'd0);
        check("mid_rst_hdr_ready", 32'(rx_hdr_ready), 32'd0);
        check("mid_rst_stat_ok", 32'(stat_ok), 32'd0);
        check("mid_rst_stat_len_err", 32'(stat_len_err), 32'd0);
        rx_payload_TVALID = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        cap_q.delete();
        cap_cyc.delete();
        @(negedge ap_clk);
        #1 check("rst2_hdr_ready", 32'(rx_hdr_ready), 32'd1);
        @(negedge ap_clk);
        send_hdr(mk_hdr(4'd5, 16'd36, 8'd17), acc);
        send_payload(16, 8'h20, 1'b1, nr);
        wait_idle();
        push_prefix(16'd16);
        push_bytes(16, 8'h20);
        check_frame("post_rst");
        check("post_rst_stat_ok", 32'(stat_ok), 32'd1);
        check("post_rst_stat_drop", 32'(stat_drop), 32'd0);
        check("post_rst_stat_len_err", 32'(stat_len_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
